// File: rtl/alu_op_sequencer.sv
// Sequencer in front of a combinational ALU: issues single-cycle ops, runs MUL as a
// shift-add loop through the ALU adder, and returns results over a valid/ready handshake.
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_cout,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [7:0]            alu_ctrl,
    output logic                  alu_cin,
    output logic                  alu_out_en,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_cout
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam logic [7:0] CTRL_ADD = 8'h2C;
    localparam logic [7:0] CTRL_SUB = 8'hAC;
    localparam logic [7:0] CTRL_AND = 8'h22;
    localparam logic [7:0] CTRL_OR  = 8'h32;
    localparam logic [7:0] CTRL_XOR = 8'h04;
    localparam logic [7:0] CTRL_NOT = 8'h45;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              op_reg;
    logic [DATA_WIDTH-1:0]   a_reg, b_reg;
    logic                    cin_reg;
    logic [DATA_WIDTH-1:0]   acc_reg, mcand_reg, mplier_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DATA_WIDTH-1:0]   rsp_data_reg;
    logic                    rsp_cout_reg, rsp_err_reg;

    function automatic logic [7:0] ctrl_word(input logic [2:0] op);
        case (op)
            3'd0:    return CTRL_ADD;
            3'd1:    return CTRL_SUB;
            3'd2:    return CTRL_AND;
            3'd3:    return CTRL_OR;
            3'd4:    return CTRL_XOR;
            3'd5:    return CTRL_NOT;
            default: return 8'h00;
        endcase
    endfunction

    logic is_arith;
    assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Every output is a decode of registered state, so req_* and rsp_ready only steer state_next.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = 8'h00;
        alu_cin    = 1'b0;
        alu_out_en = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_op == OP_MUL)      state_next = MUL;
                    else if (req_op == OP_RSV) state_next = RESP;
                    else                       state_next = EXEC;
                end
            end
            EXEC: begin
                alu_a      = a_reg;
                alu_b      = b_reg;
                alu_ctrl   = ctrl_word(op_reg);
                alu_cin    = is_arith ? cin_reg : 1'b0;
                alu_out_en = 1'b1;
                state_next = RESP;
            end
            MUL: begin
                alu_a      = acc_reg;
                alu_b      = mcand_reg;
                alu_ctrl   = CTRL_ADD;
                alu_out_en = 1'b1;
                if (cnt_reg == LAST_ITER) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            cin_reg      <= 1'b0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_cout_reg <= 1'b0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg      <= req_op;
                        a_reg       <= req_a;
                        b_reg       <= req_b;
                        cin_reg     <= req_cin;
                        acc_reg     <= '0;
                        mcand_reg   <= req_a;
                        mplier_reg  <= req_b;
                        cnt_reg     <= '0;
                        rsp_err_reg <= (req_op == OP_RSV);
                        if (req_op == OP_RSV) begin
                            rsp_data_reg <= '0;
                            rsp_cout_reg <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_reg <= alu_out;
                    rsp_cout_reg <= is_arith ? alu_cout : 1'b0;
                end
                MUL: begin
                    // Accumulate the shifted multiplicand when the current multiplier bit is set.
                    if (mplier_reg[0]) acc_reg <= alu_out;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        rsp_data_reg <= mplier_reg[0] ? alu_out : acc_reg;
                        rsp_cout_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_cout = rsp_cout_reg;
    assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU model, directed requests, and a
// scoreboard monitor that checks every response handshake against queued expectations.
module tb_alu_op_sequencer;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_a, req_b;
    logic          req_cin;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_cout, rsp_err;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [7:0]    alu_ctrl;
    logic          alu_cin, alu_out_en, alu_cout;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
        .alu_out_en(alu_out_en), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    // ALU model; logic ops report a carry of 1 so the sequencer must mask it.
    logic [DW:0] alu_sum;
    always_comb begin
        alu_sum  = '0;
        alu_out  = 16'hDEAD;
        alu_cout = 1'b1;
        if (alu_out_en) begin
            case (alu_ctrl)
                8'h2C: begin alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
                             alu_out = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
                8'hAC: begin alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{DW{1'b0}}, alu_cin};
                             alu_out = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
                8'h22: alu_out = alu_a & alu_b;
                8'h32: alu_out = alu_a | alu_b;
                8'h04: alu_out = alu_a ^ alu_b;
                8'h45: alu_out = ~alu_a;
                default: alu_out = 16'hBEEF;
            endcase
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic          cout;
        logic          err;
        string         name;
    } exp_t;
    exp_t sb[$];

    int en_cycles = 0;
    int add_cycles = 0;
    always @(negedge clk) begin
        if (alu_out_en) en_cycles++;
        if (alu_out_en && alu_ctrl == 8'h2C) add_cycles++;
    end

    // Monitor: compares each response handshake with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end else if (rsp_ready) begin
                e = sb.pop_front();
                check({e.name, "_data"}, {16'd0, rsp_data}, {16'd0, e.data});
                check({e.name, "_cout"}, {31'd0, rsp_cout}, {31'd0, e.cout});
                check({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                check({e.name, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
                $display("rsp %s: data=0x%04h cout=%0b err=%0b", e.name, rsp_data, rsp_cout, rsp_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic cin, input logic [DW-1:0] exp_data,
                          input logic exp_cout, input logic exp_err);
        int lat, en0, add0, exp_lat, exp_add;
        exp_lat = (op == 3'd7) ? 0 : (op == 3'd6) ? DW : 1;
        exp_add = (op == 3'd6) ? DW : (op == 3'd0) ? 1 : 0;
        check({name, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        en0 = en_cycles;
        add0 = add_cycles;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
        step();
        sb.push_back('{exp_data, exp_cout, exp_err, name});
        // Scramble the request bus to show the operands were captured.
        req_valid = 1'b0; req_op = 3'd0; req_a = 16'hBAD0; req_b = 16'h0BAD; req_cin = ~cin;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        step();
        check({name, "_rsp_valid_after"}, {31'd0, rsp_valid}, 32'd0);
        check({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        check({name, "_en_cycles"}, en_cycles - en0, exp_lat);
        check({name, "_add_cycles"}, add_cycles - add0, exp_add);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0;
        rsp_ready = 1'b1;
        step(); step();
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_alu_en", {31'd0, alu_out_en}, 32'd0);
        check("reset_alu_ops", {alu_a, alu_b}, 32'd0);
        check("reset_alu_ctrl", {23'd0, alu_ctrl, alu_cin}, 32'd0);
        reset_n = 1'b1;
        step();
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);

        run_op("add_7fff_1", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0);
        run_op("add_ffff_1", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_cin",    3'd0, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0);
        run_op("sub_5_3",    3'd1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("and",        3'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0);
        run_op("or",         3'd3, 16'hF0F0, 16'hFF00, 1'b1, 16'hFFF0, 1'b0, 1'b0);
        run_op("xor",        3'd4, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0, 1'b0);
        run_op("not",        3'd5, 16'h1234, 16'h0000, 1'b1, 16'hEDCB, 1'b0, 1'b0);
        run_op("mul_123_10", 3'd6, 16'h0123, 16'h0010, 1'b1, 16'h1230, 1'b0, 1'b0);
        run_op("mul_ffff_sq",3'd6, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("reserved",   3'd7, 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b0, 1'b1);
        run_op("add_post_rsv",3'd0, 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0);

        // Backpressure: response held for 5 cycles while a second request waits.
        rsp_ready = 1'b0;
        check("bp_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0;
        step();
        sb.push_back('{16'h3333, 1'b0, 1'b0, "bp_add"});
        req_op = 3'd3; req_a = 16'h00FF; req_b = 16'h0F00;
        step();
        check("bp_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_hold_data", {16'd0, rsp_data}, 32'h3333);
            check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        step();
        sb.push_back('{16'h0FFF, 1'b0, 1'b0, "bp_or"});
        req_valid = 1'b0;
        check("bp_next_accepted", {31'd0, req_ready}, 32'd0);
        step();
        check("bp_or_valid", {31'd0, rsp_valid}, 32'd1);
        step();
        check("bp_or_done", {31'd0, req_ready}, 32'd1);

        // Reset pulsed after the eighth MUL iteration: aborted, no response.
        req_valid = 1'b1; req_op = 3'd6; req_a = 16'h0003; req_b = 16'h0005; req_cin = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("mul8_busy", {31'd0, alu_out_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_alu_en", {31'd0, alu_out_en}, 32'd0);
        check("rst_mid_alu_ops", {alu_a, alu_b}, 32'd0);
        check("rst_mid_alu_ctrl", {23'd0, alu_ctrl, alu_cin}, 32'd0);
        check("rst_mid_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_mid_rsp_flags", {30'd0, rsp_cout, rsp_err}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check("rst_no_response", {31'd0, seen}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        run_op("add_after_rst", 3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("mul_after_rst", 3'd6, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencing front end for the execution unit's combinational ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's operand, control-word, carry-in and output-enable inputs, then captures the ALU result and returns it over a second valid/ready handshake. Single-cycle ops occupy the ALU for one cycle. MUL runs as an iterative shift-add loop through the same ALU, so the execution unit needs no separate multiplier.

## Interface
- DATA_WIDTH, 16, operand/result width; must match the attached ALU.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at clk edge.
- req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 MUL, 7 reserved.
- req_a, req_b  in  DATA_WIDTH  operands.
- req_cin  in  1  carry-in, used by ADD/SUB only.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_WIDTH  result.
- rsp_cout  out  1  carry out (ADD/SUB only, else 0).
- rsp_err  out  1  set for reserved opcode.
- alu_a, alu_b  out  DATA_WIDTH  ALU operands.
- alu_ctrl  out  8  ALU control word.
- alu_cin  out  1  ALU carry-in.
- alu_out_en  out  1  ALU output enable.
- alu_out  in  DATA_WIDTH  ALU result.
- alu_cout  in  1  ALU carry out.

## Operation
- Control words (fixed constants):
  - ADD 8'h2C
  - SUB 8'hAC
  - AND 8'h22
  - OR 8'h32
  - XOR 8'h04
  - NOT 8'h45
  - MUL iterations use ADD 8'h2C.
- alu_cin:
  - ADD/SUB: registered req_cin.
  - All other ops: 0.
- FSM states: IDLE, EXEC, MUL, RESP.
  - IDLE: req_ready=1. On handshake, register op/a/b/cin.
    - op 6 → MUL, with acc=0, mcand=a, mplier=b, cnt=0.
    - op 7 → RESP directly, with rsp_data=0, rsp_cout=0, rsp_err=1.
    - All other ops → EXEC.
  - EXEC: alu_a=a, alu_b=b, alu_ctrl per op, alu_out_en=1. At the edge, capture rsp_data=alu_out, rsp_cout=alu_cout (forced 0 for ops 2–5), then → RESP.
  - MUL: alu_a=acc, alu_b=mcand, alu_ctrl=8'h2C, alu_cin=0, alu_out_en=1. Each edge:
    - if mplier[0]: acc<=alu_out;
    - mcand<<=1, mplier>>=1, cnt++.
    - When cnt==DATA_WIDTH-1 at the edge: → RESP, with rsp_data = the updated acc and rsp_cout=0.
    - Always exactly DATA_WIDTH iterations; no early exit.
    - Result is the low DATA_WIDTH bits of a*b, with the carry discarded.
  - RESP: rsp_valid=1; rsp_data/rsp_cout/rsp_err stable. On rsp_ready → IDLE. rsp_err clears when the next request is accepted.
- Outside EXEC/MUL: alu_out_en=0, alu_a=alu_b=0, alu_ctrl=0, alu_cin=0.
- No new request is accepted while busy; req_ready=0 in EXEC/MUL/RESP.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, and all of the following are 0: rsp_*, alu_*, acc, mcand, mplier, cnt, and the stored op/operands. req_ready=1 once reset is released.
- Latency from request handshake at edge N to rsp_valid high:
  - ADD..NOT: rsp_valid high after edge N+1.
  - MUL: rsp_valid high after edge N+DATA_WIDTH.
  - Reserved op: rsp_valid high after edge N.
- Throughput: one request in flight. Earliest next accept is the cycle after the response handshake; req_ready rises in the same cycle the FSM returns to IDLE.
- rsp_ready held low: the response is held indefinitely with no change.
- Reset mid-MUL or mid-RESP: the operation is aborted, no response is produced, and the block returns to reset values.
- All outputs are decoded from registered state or held in registers. There is no combinational path from req_* or rsp_ready to any output.

## Test plan
- ADD:
  - 0x7FFF+0x0001, cin 0 → 0x8000, cout 0.
  - 0xFFFF+0x0001 → 0x0000, cout 1.
  - Both: rsp_valid one cycle after accept.
- SUB 0x0005−0x0003 → 0x0002.
- Logic ops on a=0xF0F0, b=0xFF00 → AND 0xF000, OR 0xFFF0, XOR 0x0FF0, all with cout 0. NOT(a=0x1234) → 0xEDCB.
- MUL:
  - 0x0123×0x0010 → 0x1230; 0xFFFF×0xFFFF → 0x0001.
  - Both: exactly 16 cycles with alu_out_en=1 and alu_ctrl=8'h2C.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, req_ready=0 throughout. The next request is accepted one cycle after the handshake.
- Reserved op 7 → rsp_err=1, rsp_data=0, alu_out_en never asserted. Reset_n pulsed at MUL iteration 8 → all outputs 0 immediately, no response after release.
